// File: rtl/music_sequencer.sv
// Table-driven melody player: steps through {dur,note} words from a 1-cycle-latency ROM,
// holding each note for dur ticks of TICK_DIV clocks, with pause, stop, loop and one-shot end.
module music_sequencer #(
  parameter int TICK_DIV  = 1250000,
  parameter int NOTE_W    = 4,
  parameter int DUR_W     = 3,
  parameter int ADDR_W    = 5,
  parameter int SONG_BASE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DUR_W+NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    speak,
  output logic                    busy,
  output logic                    beat,
  output logic                    done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(SONG_BASE);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [NOTE_W-1:0]   note_n;
  logic [DUR_W-1:0]    remaining, remaining_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic [DUR_W-1:0]    rom_dur;
  logic [NOTE_W-1:0]   rom_note;

  assign {rom_dur, rom_note} = rom_data;
  assign busy  = (state != IDLE);
  assign speak = (note != '0) && !pause && busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= BASE_ADDR;
      note      <= '0;
      remaining <= '0;
      tick_cnt  <= '0;
    end else begin
      state     <= state_n;
      rom_addr  <= addr_n;
      note      <= note_n;
      remaining <= remaining_n;
      tick_cnt  <= tick_n;
    end
  end

  // beat and done are pulses decoded from the current state; they are held low in reset
  always_comb begin
    state_n     = state;
    addr_n      = rom_addr;
    note_n      = note;
    remaining_n = remaining;
    tick_n      = tick_cnt;
    beat        = 1'b0;
    done        = 1'b0;
    if (!rst) begin
      if (stop && state != IDLE) begin
        state_n = IDLE;
        addr_n  = BASE_ADDR;
        note_n  = '0;
        tick_n  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr_n  = BASE_ADDR;
              state_n = FETCH;
            end
          end
          FETCH: state_n = LOAD;
          LOAD: begin
            if (rom_dur == '0) begin
              if (loop_en) begin
                addr_n  = BASE_ADDR;
                state_n = FETCH;
              end else begin
                note_n  = '0;
                done    = 1'b1;
                state_n = IDLE;
              end
            end else begin
              note_n      = rom_note;
              remaining_n = rom_dur;
              tick_n      = '0;
              addr_n      = rom_addr + ADDR_ONE;
              state_n     = PLAY;
            end
          end
          PLAY: begin
            // the old note keeps sounding through FETCH/LOAD so repeats are seamless
            if (!pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_n      = '0;
                beat        = 1'b1;
                remaining_n = remaining - DUR_ONE;
                if (remaining == DUR_ONE) state_n = FETCH;
              end else begin
                tick_n = tick_cnt + TICK_ONE;
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

endmodule
